booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin scheduler that shares one 5-bit-bus Booth multiplier among NREQ requesters. It accepts one operand pair at a time and sequences the multiplier's start/load handshake. It collects the two-word product from the multiplier's output bus and returns it to the winning requester with a tag. It sits between client blocks and the `bothmult` instance; the multiplier's own reset is driven separately.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 5, operand/bus width; product is 2*WIDTH, signed two's complement
- TIMEOUT_CYC, 32, max cycles in WAIT before abort (used only with macro)

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-low reset
- req_valid  in  NREQ  request pending per requester
- req_x  in  NREQ*WIDTH  multiplicand per requester, slice i = [i*WIDTH +: WIDTH]
- req_y  in  NREQ*WIDTH  multiplier per requester
- req_ready  out  NREQ  one-hot accept pulse; operands latched this cycle
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  $clog2(NREQ)  index of requester owning the response
- rsp_prod  out  2*WIDTH  product {hi,lo}
- rsp_err  out  1  timeout abort flag (tied 0 without macro)
- mul_start  out  1  start pulse to multiplier
- mul_inbus  out  WIDTH  operand bus to multiplier
- mul_outbus  in  WIDTH  result bus from multiplier
- mul_done  in  1  multiplier completion

## Operation
- FSM states: IDLE, LOAD_X, LOAD_Y, WAIT, CAP_LO, RESP.
- IDLE: if any req_valid, the arbiter picks the first set bit searching from (last_grant+1) mod NREQ upward. The block drives req_ready[g]=1 for that one cycle, latches req_x[g], req_y[g] and g, and goes to LOAD_X. No request: stays in IDLE.
- LOAD_X: mul_start=1, mul_inbus=X; -> LOAD_Y.
- LOAD_Y: mul_start=0, mul_inbus=Y; -> WAIT.
- WAIT: mul_inbus=0. When mul_done=1, the block captures mul_outbus as product high word and goes to CAP_LO.
- CAP_LO: the block captures mul_outbus as the low word; -> RESP.
- RESP: rsp_valid=1 and rsp_id, rsp_prod, rsp_err are held stable until rsp_ready=1. On that cycle the block updates last_grant=g and returns to IDLE.
- Fairness: last_grant updates only on response handshake. Requester i is re-eligible only after the other pending requesters are served.
- req_valid deasserting while not granted: no effect. Operands are sampled only on the accept cycle.
- mul_done outside WAIT: ignored.
- Reset (rst=0 at an edge): state=IDLE, last_grant=NREQ-1 (so requester 0 has first priority). All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_start, mul_inbus. Any operation in flight is dropped without a response.

## Timing
- Accept at cycle T; mul_start=1 at T+1; Y on bus at T+2; earliest mul_done at T+3.
- mul_done at cycle D: low word sampled at D+1, rsp_valid=1 from D+2.
- Minimum request-to-response: 5 cycles. Back-to-back: next accept is no earlier than the cycle after the rsp handshake.
- Outputs are registered from state (Moore). req_ready is a combinational decode of IDLE plus arbiter choice.

## Configuration
- BOOTH_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on entry.
  - If TIMEOUT_CYC cycles elapse without mul_done, the FSM goes directly to RESP with rsp_err=1 and rsp_prod=0.
  - rsp_err is cleared on the next accept.
- Not defined: no counter; WAIT holds indefinitely; rsp_err constant 0.

## Structure
- Package booth_arb_pkg: state enum type, default WIDTH/NREQ constants.
- Sub-module rr_arbiter: request vector plus last_grant in, one-hot grant and encoded index out, combinational. The pointer register stays in the parent.

## Test plan
- Single request, req 0, X=3, Y=-2 (5'b11110), model mul_done at T+3 -> rsp_prod=10'h3FA, rsp_id=0, rsp_valid at T+5.
- All four req_valid held high continuously -> accepts in order 0,1,2,3,0; no requester is starved.
- rsp_ready low for 4 cycles in RESP -> rsp_valid/rsp_prod stable, no new req_ready until handshake.
- rst=0 asserted during WAIT -> next cycle all outputs 0, state IDLE. A fresh request on req 2 with req 0 also valid -> req 0 granted first.
- With BOOTH_ARB_TIMEOUT_EN and TIMEOUT_CYC=32, model never asserts mul_done -> rsp_valid with rsp_err=1, rsp_prod=0 at 32 cycles after WAIT entry.
- Spurious mul_done pulse during IDLE and LOAD_Y -> ignored; product taken only from the done pulse in WAIT.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
package booth_arb_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_WIDTH       = 5;
  localparam int DEF_TIMEOUT_CYC = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_Y,
    ST_WAIT,
    ST_CAP_LO,
    ST_RESP
  } state_e;

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    gnt_any
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one bus-serial Booth multiplier among NREQ clients.
// Optional WAIT-state abort is enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]      rsp_prod,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_inbus,
  input  logic [WIDTH-1:0]        mul_outbus,
  input  logic                    mul_done
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("booth_mult_arbiter: parameter out of range");
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [IDX_W-1:0]        gid_q, gid_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0]        hi_q, hi_d;

  logic                    mul_start_q, mul_start_d;
  logic [WIDTH-1:0]        mul_inbus_q, mul_inbus_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]        rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]      rsp_prod_q, rsp_prod_d;

  logic [NREQ-1:0]         arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    accept;
  logic                    tmo_hit;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // Grant is only offered while idle and out of reset, so a held reset never accepts.
  assign accept    = (state_q == ST_IDLE) && arb_any && rst;
  assign req_ready = accept ? arb_gnt : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    x_d          = x_q;
    y_d          = y_q;
    hi_d         = hi_q;
    rsp_id_d     = rsp_id_q;
    rsp_prod_d   = rsp_prod_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gid_d   = arb_idx;
          x_d     = req_x[arb_idx*WIDTH +: WIDTH];
          y_d     = req_y[arb_idx*WIDTH +: WIDTH];
          state_d = ST_LOAD_X;
        end
      end
      ST_LOAD_X: state_d = ST_LOAD_Y;
      ST_LOAD_Y: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          hi_d    = mul_outbus;
          state_d = ST_CAP_LO;
        end else if (tmo_hit) begin
          rsp_id_d   = gid_q;
          rsp_prod_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_CAP_LO: begin
        rsp_id_d   = gid_q;
        rsp_prod_d = {hi_q, mul_outbus};
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          last_grant_d = gid_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Moore outputs registered from the next state so they align with it.
    mul_start_d = (state_d == ST_LOAD_X);
    rsp_valid_d = (state_d == ST_RESP);
    case (state_d)
      ST_LOAD_X: mul_inbus_d = x_d;
      ST_LOAD_Y: mul_inbus_d = y_q;
      default:   mul_inbus_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      gid_q        <= '0;
      mul_start_q  <= 1'b0;
      mul_inbus_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_prod_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      mul_start_q  <= mul_start_d;
      mul_inbus_q  <= mul_inbus_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_prod_q   <= rsp_prod_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q  <= x_d;
    y_q  <= y_d;
    hi_q <= hi_d;
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // Counter is zero outside WAIT, so it restarts on every WAIT entry.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = (state_q == ST_WAIT) ? tmo_cnt_q + 1'b1 : '0;
    rsp_err_d = rsp_err_q;
    if (accept) begin
      rsp_err_d = 1'b0;
    end else if ((state_q == ST_WAIT) && !mul_done && tmo_hit) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign mul_start = mul_start_q;
  assign mul_inbus = mul_inbus_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter; the bench plays the multiplier's bus side.
module tb_booth_mult_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  rsp_err;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_inbus;
  logic [WIDTH-1:0]      mul_outbus;
  logic                  mul_done;

  int checks = 0;
  int errors = 0;

  booth_mult_arbiter #(
    .NREQ        (NREQ),
    .WIDTH       (WIDTH),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .rsp_err    (rsp_err),
    .mul_start  (mul_start),
    .mul_inbus  (mul_inbus),
    .mul_outbus (mul_outbus),
    .mul_done   (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; expected operands and product are hand-computed by the caller.
  task automatic serve(input int g, input logic [4:0] ex, input logic [4:0] ey,
                       input logic [9:0] ep, input int hold, input bit spur);
    #1;
    chk("accept_onehot", 32'(req_ready), 32'(1) << g);
    tick();
    chk("loadx_start", 32'(mul_start), 32'd1);
    chk("loadx_bus", 32'(mul_inbus), 32'(ex));
    chk("loadx_ready", 32'(req_ready), 32'd0);
    tick();
    chk("loady_start", 32'(mul_start), 32'd0);
    chk("loady_bus", 32'(mul_inbus), 32'(ey));
    if (spur) begin
      mul_done   = 1'b1;
      mul_outbus = 5'h0A;
    end
    tick();
    chk("wait_bus", 32'(mul_inbus), 32'd0);
    mul_done   = 1'b1;
    mul_outbus = ep[9:5];
    tick();
    mul_done   = 1'b0;
    mul_outbus = ep[4:0];
    chk("caplo_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_prod", 32'(rsp_prod), 32'(ep));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    mul_outbus = 5'h13;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_prod", 32'(rsp_prod), 32'(ep));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    mul_done   = 1'b0;
    mul_outbus = '0;
    // x: {15, -16, -5, 3}; y: {15, -16, 7, -2}
    req_x = {5'd15, 5'b10000, 5'b11011, 5'd3};
    req_y = {5'd15, 5'b10000, 5'd7, 5'b11110};

    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_inbus", 32'(mul_inbus), 32'd0);

    rst        = 1'b1;
    mul_done   = 1'b1;
    mul_outbus = 5'h15;
    tick();
    mul_done = 1'b0;
    chk("idle_spur_start", 32'(mul_start), 32'd0);
    chk("idle_spur_valid", 32'(rsp_valid), 32'd0);

    // 3 * -2 = -6 -> 10'h3FA, with a stray done while Y is on the bus
    req_valid = 4'b0001;
    serve(0, 5'd3, 5'b11110, 10'h3FA, 0, 1'b1);
    req_valid = 4'b0000;

    // Reset in WAIT drops the operation; with last_grant=0 requester 1 wins first
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_accept", 32'(req_ready), 32'b0010);
    tick();
    tick();
    tick();
    chk("pre_rst_wait_bus", 32'(mul_inbus), 32'd0);
    rst       = 1'b0;
    req_valid = 4'b1111;
    tick();
    chk("wrst_req_ready", 32'(req_ready), 32'd0);
    chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("wrst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("wrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("wrst_mul_start", 32'(mul_start), 32'd0);
    chk("wrst_mul_inbus", 32'(mul_inbus), 32'd0);
    rst = 1'b1;

    // All requesters held valid: service order 0,1,2,3,0
    serve(0, 5'd3, 5'b11110, 10'h3FA, 0, 1'b0);
    serve(1, 5'b11011, 5'd7, 10'h3DD, 4, 1'b0);
    serve(2, 5'b10000, 5'b10000, 10'h100, 0, 1'b0);
    serve(3, 5'd15, 5'd15, 10'h0E1, 0, 1'b0);
    serve(0, 5'd3, 5'b11110, 10'h3FA, 0, 1'b0);

    req_valid = '0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion expected finish within 20000");
    $fatal(1, "bench time limit");
  end

endmodule
